inst_fetch_queue: RTL
=====================

# inst_fetch_queue

Fetch-side prefetch queue that sits directly upstream of the instruction decoder. It generates sequential PCs and issues them on an SRAM-like instruction port with request/address-ok/data-ok handshakes. It buffers returned words with their PCs in a DEPTH-entry in-order queue and presents them to decode through a valid/ready handshake. On a branch or exception redirect it flushes the queue and silently drops responses still in flight.

## Interface

Parameters:
- DEPTH, 4, queue entries and maximum outstanding-plus-buffered words; power of two, ≥2.
- RESET_PC, 32'hbfc00000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address, always the current fetch PC.
- inst_addr_ok  in  1  request accepted this cycle (counts only when inst_req=1).
- inst_rdata  in  32  returned instruction word.
- inst_data_ok  in  1  one in-order response this cycle.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; word-aligned by caller.
- f_valid  out  1  head entry valid to decode.
- f_inst  out  32  head instruction; 32'h0 when f_valid=0.
- f_pc  out  32  head PC; 32'h0 when f_valid=0.
- f_ready  in  1  decode accepts head this cycle.

## Operation

State:
- fetch_pc
- resp_pc (PC of next expected response)
- queue storage: DEPTH × {inst, pc}, with head/tail pointers and occupancy count (0..DEPTH)
- outstanding (accepted requests not yet answered, 0..DEPTH)
- discard (subset of outstanding to drop, 0..DEPTH)

Request side:
- inst_req = resetn & ~redirect_valid & (occupancy + outstanding < DEPTH). The credit check guarantees the queue never overflows.
- On an accepted request (inst_req & inst_addr_ok): fetch_pc += 4 (mod 2^32 wrap) and outstanding += 1.

Response side (inst_data_ok):
- Always: outstanding -= 1.
- If discard ≠ 0: drop the word and decrement discard.
- Otherwise: push {inst_rdata, resp_pc} at tail and increment resp_pc by 4.
- inst_data_ok with outstanding=0 is a protocol violation; the bench asserts this never happens.

Pop:
- f_valid & f_ready advances the head.
- Push and pop may occur in the same cycle, including at occupancy=DEPTH-1 and at full with pop. Occupancy changes by +1, 0 or -1 accordingly.

Redirect (priority over everything except reset):
- Queue cleared: occupancy=0, pointers reset.
- fetch_pc and resp_pc set to redirect_pc.
- discard set to the post-cycle outstanding count, i.e. outstanding − inst_data_ok. No new request is accepted because inst_req is low.
- A response arriving in the redirect cycle is dropped.
- A pop in the same cycle is ignored; the entry is flushed anyway.
- Back-to-back redirects: the last one wins, and discard is recomputed each time.

Reset (resetn=0 at an edge):
- fetch_pc=RESET_PC, resp_pc=RESET_PC, occupancy=0, outstanding=0, discard=0.
- Responses arriving during reset are ignored.
- Reset mid-transaction abandons all in-flight words. The memory side is reset by the same resetn.

## Timing

Reset values and outputs:
- During reset: inst_req=0, f_valid=0, f_inst=0, f_pc=0.
- First cycle after release: inst_req=1, inst_addr=RESET_PC.
- f_valid/f_inst/f_pc are driven from registers. inst_req is combinational from state and redirect_valid only. inst_addr = fetch_pc.

Latency and throughput:
- Request accepted in cycle T, data_ok earliest at T+1, head visible (f_valid=1) at T+2.
- Sustained throughput is 1 word/cycle when memory accepts and answers every cycle and f_ready=1.

After a redirect in cycle R:
- f_valid=0 in R+1.
- inst_req=1 with inst_addr=redirect_pc in R+1 if credit allows. In-flight words still count against credit until drained.

While f_ready=0 and queue full:
- inst_req=0.
- Head outputs are held stable.

## Test plan

- Reset release, memory always ready with 1-cycle data_ok, f_ready=1 → f_pc sequence bfc00000, bfc00004, bfc00008… from cycle 2, one per cycle, f_inst matching memory.
- f_ready=0 for 10 cycles with DEPTH=4 → exactly 4 requests accepted, occupancy 4, inst_req=0, head holds bfc00000. Releasing f_ready → 4 pops in order with no gap; fetch resumes.
- Three requests outstanding with no data_ok yet, then redirect_pc=0x80001000 → next three data_ok words dropped. First f_valid shows f_pc=0x80001000 with its word; no stale PC is ever visible.
- Redirect in the same cycle as data_ok and f_ready pop → that word dropped, f_valid=0 next cycle, discard = outstanding−1.
- addr_ok withheld randomly, data_ok delayed 1–5 cycles, random f_ready → decode stream equals sequential reference with no loss or duplication; occupancy+outstanding never exceeds 4.
- fetch_pc=0xfffffffc, sequential fetch → next address 0x00000000 (wrap). Assert resetn during three outstanding requests → all outputs at reset values the next cycle, fetch restarts at bfc00000.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Prefetch queue in front of the instruction decoder. Issues sequential
//   fetch PCs on an SRAM-like port (req / addr_ok / data_ok), buffers the
//   returned words with their PCs in a DEPTH-entry in-order queue, and hands
//   them to decode over a valid/ready handshake. A redirect flushes the
//   queue, restarts fetch at redirect_pc and drops responses still in flight.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   inst_req/inst_addr     fetch request and its address (current fetch PC)
//   inst_addr_ok           request accepted this cycle
//   inst_rdata/inst_data_ok in-order response word and its strobe
//   redirect_valid/_pc     flush and restart fetch at redirect_pc
//   f_valid/f_inst/f_pc    head entry to decode (zero when not valid)
//   f_ready                decode consumes the head this cycle
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  output logic [31:0] f_inst,
  output logic [31:0] f_pc,
  input  logic        f_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        discard_q, discard_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_inst_q, f_inst_d;
  logic [31:0] f_pc_q, f_pc_d;

  logic        accept;
  logic        push;
  logic        pop;
  logic [CW:0] credit;

  // Buffered plus outstanding words may never exceed the queue size, so
  // every accepted request is guaranteed a slot when its data returns.
  assign credit    = {1'b0, count_q} + {1'b0, outst_q};
  assign inst_req  = resetn & ~redirect_valid & (credit < DEPTH_C);
  assign inst_addr = fetch_pc_q;
  assign accept    = inst_req & inst_addr_ok;

  assign pop  = f_valid_q & f_ready & ~redirect_valid;
  assign push = inst_data_ok & ~redirect_valid & (discard_q == '0);

  assign f_valid = f_valid_q;
  assign f_inst  = f_inst_q;
  assign f_pc    = f_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    discard_d  = discard_q;
    outst_d    = outst_q + cnt_t'(accept) - cnt_t'(inst_data_ok);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      // Everything still in flight after this cycle belongs to the old path.
      discard_d  = outst_q - cnt_t'(inst_data_ok);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (inst_data_ok && (discard_q != '0)) discard_d = discard_q - cnt_t'(1);
      if (push) begin
        tail_d    = tail_q + ptr_t'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) head_d = head_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end

    // Head outputs are registered: look ahead at the entry that will be the
    // head after this edge, bypassing the word being pushed when it lands
    // straight at the head slot.
    f_valid_d = (count_d != '0);
    f_inst_d  = '0;
    f_pc_d    = '0;
    if (f_valid_d) begin
      if (push && (head_d == tail_q)) begin
        f_inst_d = inst_rdata;
        f_pc_d   = resp_pc_q;
      end else begin
        f_inst_d = inst_mem_q[head_d];
        f_pc_d   = pc_mem_q[head_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      f_valid_q  <= 1'b0;
      f_inst_q   <= '0;
      f_pc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      f_valid_q  <= f_valid_d;
      f_inst_q   <= f_inst_d;
      f_pc_q     <= f_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      inst_mem_q[tail_q] <= inst_rdata;
      pc_mem_q[tail_q]   <= resp_pc_q;
    end
  end

endmodule
